pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Shares the single burst-mode physical memory port between the instruction-cache and data-cache miss paths. It sits below both caches and above main memory. It arbitrates line requests and serializes each 256-bit line into 64-bit beats, for writebacks, or assembles beats into a line, for fills. It returns a one-cycle response to the granted cache only.

## Interface
- LINE_W, 256: cache line width in bits.
- BEAT_W, 64: memory beat width. BEATS = LINE_W/BEAT_W, a power of two ≥ 2.
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- i_read  in  1  icache line-fill request. Held until i_resp.
- i_addr  in  32  icache line address. Bits [4:0] are ignored.
- i_rdata  out  LINE_W  assembled line. Valid only while i_resp is high.
- i_resp  out  1  one-cycle completion pulse to the icache.
- d_read  in  1  dcache line-fill request. Held until d_resp.
- d_write  in  1  dcache writeback request. Held until d_resp.
- d_addr  in  32  dcache line address. Bits [4:0] are ignored.
- d_wdata  in  LINE_W  writeback line. Must be stable while d_write is high.
- d_rdata  out  LINE_W  assembled line. Valid only while d_resp is high.
- d_resp  out  1  one-cycle completion pulse to the dcache.
- pmem_read  out  1  burst read strobe. Held for the whole burst.
- pmem_write  out  1  burst write strobe. Held for the whole burst.
- pmem_addr  out  32  line-aligned burst address, with [4:0] = 0.
- pmem_wdata  out  BEAT_W  current write beat. Beat 0 is line bits [63:0].
- pmem_rdata  in  BEAT_W  read beat. Valid when pmem_resp is high.
- pmem_resp  in  1  one accepted or returned beat per high cycle. Gaps between beats are allowed.

## Operation
- The arbiter has four states: IDLE, RD_BURST, WR_BURST and DONE.
- In IDLE, on each rising edge, the pending requests are evaluated and a grant is chosen:
  - Only one cache requesting: that cache is granted.
  - Both caches requesting: the cache not served last is granted. A single `last_grant` flag implements this and resets to ICACHE, so the dcache wins the first tie.
- On a grant, the arbiter latches the grant, the aligned address and, for writes, d_wdata. It clears beat_cnt and moves to RD_BURST or WR_BURST.
- d_write together with d_read is a caller error. In that case d_write wins and d_read is ignored for that grant.
- RD_BURST: pmem_read = 1. On each cycle with pmem_resp high, pmem_rdata goes into line-buffer slot beat_cnt and beat_cnt increments. After the beat with beat_cnt = BEATS-1, the state moves to DONE.
- WR_BURST: pmem_write = 1 and pmem_wdata = wbuf[beat_cnt]. Advancement follows the same pmem_resp and beat_cnt rule as RD_BURST.
- DONE: the arbiter pulses the granted cache's resp for exactly one cycle and drives x_rdata from the line buffer. It updates last_grant and returns to IDLE. Requests are not sampled in DONE.
- The requester drops its request in the cycle after resp, so it is not re-granted.
- pmem_resp while in IDLE or DONE is ignored.
- beat_cnt wraps mod BEATS. It is never observed past BEATS-1.

## Timing
- Reset values:
  - All outputs are 0, including i_rdata, d_rdata and pmem_addr.
  - State is IDLE, beat_cnt is 0 and last_grant is ICACHE.
- Reset mid-burst: the arbiter returns to IDLE immediately (asynchronously). The partial line is discarded and no resp is issued. The memory model is reset with it.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Minimum latency, with the request arriving before edge 0 and pmem_resp high on the first strobe cycle:
  - Strobe high in cycles 1 through BEATS.
  - resp in cycle BEATS+1, which is cycle 5 with the defaults.
  - Next grant evaluated at edge BEATS+2.
- Each stall cycle, where pmem_resp is low during a burst, adds exactly one cycle.
- pmem_addr is stable from the grant until DONE. The strobe drops in DONE.

## Structure
- Add `pmem_arb_state_t` (IDLE, RD_BURST, WR_BURST, DONE) to rv32i_types.
- Add `pmem_grant_t` (ICACHE, DCACHE) to rv32i_types.
- Use one sub-module, `pmem_burst_adaptor`. It owns beat_cnt, the line buffer, wbuf and beat mux/demux, and reports `burst_done`. The arbiter FSM drives its start, dir and latch signals.

## Test plan
- Icache read of 0x0000_1234, memory returns beats 0x11..11 through 0x44..44 back to back -> pmem_addr = 0x0000_1220 and i_resp in cycle 5 with i_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}. d_resp stays 0.
- Dcache write of line 0xAAAA_…_0001 at 0x8000_0040 with pmem_resp gaps of 2 cycles between beats -> beats are emitted in order 0 to 3, each held until its resp. d_resp comes one cycle after the 4th beat.
- Both caches requesting at once from reset -> dcache served first. The icache is granted at the next IDLE edge even though the dcache immediately re-requests.
- Reset asserted after beat 2 of an icache fill -> outputs go to 0 at once, no i_resp. A fresh request after reset completes normally with correct data.
- d_read and d_write both high -> a write burst is performed, with no read strobe.
- pmem_resp pulsed while IDLE -> no state change and no resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the physical-memory arbiter: FSM state, grant owner and
// the line-address alignment helper used by both cache request paths.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } pmem_arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } pmem_grant_t;

    localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/pmem_burst_adaptor.sv
// Beat serializer/deserializer: holds the writeback line and the fill buffer,
// walks beat_cnt on every accepted beat and flags the final beat.
module pmem_burst_adaptor
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_dir,
    input  logic              active,
    input  logic [LINE_W-1:0] line_in,
    input  logic              beat_resp,
    input  logic [BEAT_W-1:0] beat_rdata,
    output logic [BEAT_W-1:0] beat_wdata,
    output logic [LINE_W-1:0] line_out,
    output logic              burst_done
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);

    logic [BEATS-1:0][BEAT_W-1:0] wbuf_q, wbuf_d;
    logic [BEATS-1:0][BEAT_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]             beat_cnt_q, beat_cnt_d;
    logic                         beat_fire;

    assign beat_fire = active && beat_resp;

    always_comb begin
        wbuf_d     = wbuf_q;
        line_d     = line_q;
        beat_cnt_d = beat_cnt_q;
        if (start) begin
            wbuf_d     = line_in;
            beat_cnt_d = '0;
        end else if (beat_fire) begin
            if (!wr_dir) line_d[beat_cnt_q] = beat_rdata;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_q     <= '0;
            line_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            wbuf_q     <= wbuf_d;
            line_q     <= line_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Beat mux is forced to zero outside a write burst so idle pmem_wdata stays clean.
    assign beat_wdata = (active && wr_dir) ? wbuf_q[beat_cnt_q] : '0;
    assign line_out   = line_q;
    assign burst_done = beat_fire && (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port and returns
// a single-cycle resp with the assembled line to whichever cache was granted.
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    pmem_arb_state_t   state_q, state_d;
    pmem_grant_t       grant_q, grant_d;
    pmem_grant_t       last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic              start;
    logic              d_req;
    logic              burst_done;
    logic [LINE_W-1:0] line_buf;

    assign d_req = d_read || d_write;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        start        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    // On a tie the cache that was not served last wins.
                    if (i_read && d_req)
                        grant_d = (last_grant_q == ICACHE) ? DCACHE : ICACHE;
                    else
                        grant_d = d_req ? DCACHE : ICACHE;
                    start = 1'b1;
                    if (grant_d == DCACHE) begin
                        addr_d  = line_align(d_addr);
                        state_d = d_write ? WR_BURST : RD_BURST;
                    end else begin
                        addr_d  = line_align(i_addr);
                        state_d = RD_BURST;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_done) state_d = DONE;
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= ICACHE;
            last_grant_q <= ICACHE;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
        end
    end

    pmem_burst_adaptor #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) u_adaptor (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_dir    (state_q == WR_BURST),
        .active    (pmem_read || pmem_write),
        .line_in   (d_wdata),
        .beat_resp (pmem_resp),
        .beat_rdata(pmem_rdata),
        .beat_wdata(pmem_wdata),
        .line_out  (line_buf),
        .burst_done(burst_done)
    );

    assign pmem_read  = (state_q == RD_BURST);
    assign pmem_write = (state_q == WR_BURST);
    assign pmem_addr  = addr_q;

    assign i_resp  = (state_q == DONE) && (grant_q == ICACHE);
    assign d_resp  = (state_q == DONE) && (grant_q == DCACHE);
    assign i_rdata = i_resp ? line_buf : '0;
    assign d_rdata = d_resp ? line_buf : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a small burst memory responder plus a linear
// sequence of request scenarios with hand-computed expectations.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         i_resp, d_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [31:0]  pmem_addr;
    logic [63:0]  pmem_wdata, pmem_rdata;

    logic         mem_en, mem_resp, man_resp;
    int           gap, idx, wait_cnt;
    logic [63:0]  rd_beats [4];
    logic [63:0]  wr_log   [4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pmem_resp = mem_resp | man_resp;

    pmem_arbiter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // Memory model: answers each strobe cycle after `gap` idle cycles per beat.
    always @(posedge clk or posedge rst) begin
        #1;
        if (rst) begin
            mem_resp = 1'b0; idx = 0; wait_cnt = 0;
        end else if (mem_en && (pmem_read || pmem_write)) begin
            if (wait_cnt > 0) begin
                mem_resp = 1'b0;
                wait_cnt--;
            end else begin
                mem_resp    = 1'b1;
                pmem_rdata  = rd_beats[idx];
                wr_log[idx] = pmem_wdata;
                idx         = (idx + 1) % 4;
                wait_cnt    = gap;
            end
        end else begin
            mem_resp = 1'b0; idx = 0; wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input bit want_d, input int max_cyc, output int lat,
                              output int strobes, output bit saw_rd, output bit saw_other,
                              output logic [31:0] first_addr);
        lat = -1; strobes = 0; saw_rd = 0; saw_other = 0; first_addr = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (pmem_read) saw_rd = 1;
            if (pmem_read || pmem_write) begin
                if (strobes == 0) first_addr = pmem_addr;
                strobes++;
            end
            if (want_d ? i_resp : d_resp) saw_other = 1;
            if (want_d ? d_resp : i_resp) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_beats(input logic [63:0] b0, b1, b2, b3);
        rd_beats[0] = b0; rd_beats[1] = b1; rd_beats[2] = b2; rd_beats[3] = b3;
    endtask

    int          lat, strobes;
    bit          saw_rd, saw_other;
    logic [31:0] faddr;

    initial begin
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; i_addr = '0; d_addr = '0;
        d_wdata = '0; mem_en = 1; man_resp = 0; gap = 0;
        load_beats(64'h0, 64'h0, 64'h0, 64'h0);
        @(negedge clk);

        // Reset state.
        check("rst_pmem_read",  pmem_read,  0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_addr",  pmem_addr,  0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_i_resp",     i_resp,     0);
        check("rst_d_resp",     d_resp,     0);
        check("rst_i_rdata",    i_rdata,    0);
        check("rst_d_rdata",    d_rdata,    0);
        rst = 1'b0;
        @(negedge clk);

        // 1: icache fill, back-to-back beats, minimum latency.
        load_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        i_read = 1; i_addr = 32'h0000_1234;
        wait_pulse(0, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t1_lat",     lat,     5);
        check("t1_strobes", strobes, 4);
        check("t1_addr",    faddr,   32'h0000_1220);
        check("t1_rdata",   i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("t1_d_resp",  saw_other, 0);
        check("t1_strobe_drop", pmem_read, 0);
        i_read = 0;
        @(negedge clk);
        check("t1_resp_one_cycle", i_resp, 0);

        // 2: dcache writeback with two idle cycles between beats.
        gap = 2;
        d_write = 1; d_addr = 32'h8000_0040;
        d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_0001};
        wait_pulse(1, 40, lat, strobes, saw_rd, saw_other, faddr);
        check("t2_lat",     lat,     11);
        check("t2_strobes", strobes, 10);
        check("t2_addr",    faddr,   32'h8000_0040);
        check("t2_no_read", saw_rd,  0);
        check("t2_beat0",   wr_log[0], 64'hAAAA_AAAA_AAAA_0001);
        check("t2_beat1",   wr_log[1], 64'hBBBB_BBBB_BBBB_BBBB);
        check("t2_beat2",   wr_log[2], 64'hCCCC_CCCC_CCCC_CCCC);
        check("t2_beat3",   wr_log[3], 64'hDDDD_DDDD_DDDD_DDDD);
        d_write = 0; gap = 0;

        // 3: simultaneous requests from reset, dcache re-requests at once.
        do_reset();
        load_beats(64'h0101, 64'h0202, 64'h0303, 64'h0404);
        i_read = 1; i_addr = 32'h0000_0200;
        d_read = 1; d_addr = 32'h0000_0100;
        wait_pulse(1, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t3_d_first_lat",  lat,       5);
        check("t3_d_first_addr", faddr,     32'h0000_0100);
        check("t3_no_i_resp",    saw_other, 0);
        check("t3_d_rdata",      d_rdata,   {64'h0404, 64'h0303, 64'h0202, 64'h0101});
        wait_pulse(0, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t3_i_second_lat",  lat,       6);
        check("t3_i_second_addr", faddr,     32'h0000_0200);
        check("t3_no_d_resp",     saw_other, 0);
        i_read = 0; d_read = 0;
        @(negedge clk);

        // 4: reset during an icache fill, then a clean fill.
        load_beats(64'h9999, 64'h8888, 64'h7777, 64'h6666);
        i_read = 1; i_addr = 32'h0000_2040;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_rst_read",  pmem_read, 0);
        check("t4_rst_addr",  pmem_addr, 0);
        check("t4_rst_iresp", i_resp,    0);
        @(negedge clk);
        check("t4_rst_iresp_hold", i_resp, 0);
        rst = 1'b0;
        i_addr = 32'h0000_3000;
        load_beats(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        wait_pulse(0, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t4_lat",   lat,   5);
        check("t4_addr",  faddr, 32'h0000_3000);
        check("t4_rdata", i_rdata, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                    64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        i_read = 0;
        @(negedge clk);

        // 5: d_read with d_write performs a write burst only.
        d_read = 1; d_write = 1; d_addr = 32'h4000_009F;
        d_wdata = {64'h0D, 64'h0C, 64'h0B, 64'h0A};
        wait_pulse(1, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t5_lat",     lat,       5);
        check("t5_addr",    faddr,     32'h4000_0080);
        check("t5_no_read", saw_rd,    0);
        check("t5_beat0",   wr_log[0], 64'h0A);
        check("t5_beat3",   wr_log[3], 64'h0D);
        d_read = 0; d_write = 0;
        @(negedge clk);

        // 6: stray pmem_resp while idle must not move the FSM or beat counter.
        mem_en = 0; man_resp = 1;
        repeat (3) @(negedge clk);
        check("t6_idle_read",  pmem_read,  0);
        check("t6_idle_write", pmem_write, 0);
        check("t6_idle_iresp", i_resp,     0);
        check("t6_idle_dresp", d_resp,     0);
        man_resp = 0; mem_en = 1;
        load_beats(64'hA1, 64'hB2, 64'hC3, 64'hD4);
        i_read = 1; i_addr = 32'h0000_0060;
        wait_pulse(0, 20, lat, strobes, saw_rd, saw_other, faddr);
        check("t6_lat",   lat,     5);
        check("t6_rdata", i_rdata, {64'hD4, 64'hC3, 64'hB2, 64'hA1});
        i_read = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
